// File: rtl/ext_sram_target.sv
// Far-end responder for the multiplexed 16-bit external SRAM bus.
// Turns each decoded ALE/WE/OE bus cycle into one valid/ready memory request.
module ext_sram_target #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_din,
    input  logic        ale0,
    input  logic        ale1,
    input  logic        we,
    input  logic        oe,
    input  logic        bhe,
    output logic [15:0] bus_dout,
    output logic        bus_drive,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [30:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, WR_DATA, WR_REQ, RD_REQ, RD_HOLD, IGNORE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] addr_lo;
    logic [15:0] pend_lo;
    logic [14:0] addr_hi;
    logic        ble;
    logic        hi_seen;
    logic        pend_ale0;
    logic        oe_lost;
    logic [7:0]  cnt;

    logic [14:0] hi_new;
    logic        ble_new;
    logic        take;
    logic        match;
    logic        resume;
    logic [15:0] resume_lo;

    // Address high half may arrive with the strobe or earlier; a fresh ale1 wins.
    assign hi_new    = ale1 ? bus_din[14:0] : addr_hi;
    assign ble_new   = ale1 ? bus_din[15] : ble;
    assign take      = ale1 | hi_seen;
    assign match     = ((({hi_new, addr_lo, 1'b0} ^ ADDR_BASE) & ADDR_MASK) == 32'd0);
    assign resume    = ale0 | pend_ale0;
    assign resume_lo = ale0 ? bus_din : pend_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_lo   <= '0;
            pend_lo   <= '0;
            addr_hi   <= '0;
            ble       <= 1'b0;
            hi_seen   <= 1'b0;
            pend_ale0 <= 1'b0;
            oe_lost   <= 1'b0;
            cnt       <= '0;
            bus_dout  <= '0;
            bus_drive <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            cnt <= '0;
            case (state)
                IDLE: begin
                    if (ale0) begin
                        addr_lo <= bus_din;
                        hi_seen <= 1'b0;
                        state   <= ADDR_HI;
                    end
                end
                ADDR_HI: begin
                    if (ale0) begin
                        addr_lo <= bus_din;
                        hi_seen <= 1'b0;
                    end else begin
                        addr_hi  <= hi_new;
                        ble      <= ble_new;
                        mem_addr <= {hi_new, addr_lo};
                        if (take && !match) begin
                            state <= IGNORE;
                        end else if (take && oe) begin
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_be    <= 2'b11;
                            oe_lost   <= 1'b0;
                            state     <= RD_REQ;
                        end else if (take && we) begin
                            state <= WR_DATA;
                        end else begin
                            hi_seen <= hi_seen | ale1;
                            if (cnt == TMO_LAST) begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (ale0) begin
                        addr_lo <= bus_din;
                        hi_seen <= 1'b0;
                        state   <= ADDR_HI;
                    end else begin
                        mem_wdata <= bus_din;
                        mem_be    <= {bhe, ble};
                        if ({bhe, ble} != 2'b00) begin
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WR_REQ, RD_REQ: begin
                    // A read is only served if oe stayed up for the whole request.
                    if (state == RD_REQ && !oe) begin
                        oe_lost <= 1'b1;
                        err     <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        pend_ale0 <= 1'b0;
                        hi_seen   <= 1'b0;
                        if (resume) begin
                            addr_lo <= resume_lo;
                            state   <= ADDR_HI;
                        end else if (state == RD_REQ && oe && !oe_lost) begin
                            bus_dout  <= mem_rdata;
                            bus_drive <= 1'b1;
                            state     <= RD_HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (ale0) begin
                        pend_ale0 <= 1'b1;
                        pend_lo   <= bus_din;
                    end
                end
                RD_HOLD: begin
                    if (ale0) begin
                        bus_drive <= 1'b0;
                        addr_lo   <= bus_din;
                        hi_seen   <= 1'b0;
                        state     <= ADDR_HI;
                    end else if (!oe) begin
                        bus_drive <= 1'b0;
                        state     <= IDLE;
                    end else if (cnt == TMO_LAST) begin
                        err       <= 1'b1;
                        bus_drive <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                IGNORE: begin
                    if (ale0) begin
                        addr_lo <= bus_din;
                        hi_seen <= 1'b0;
                        state   <= ADDR_HI;
                    end else if (!oe && !we) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
